mm_d_writeback_arb: RTL and testbench

//  Round-robin scheduler that shares one D-result BRAM write port among N1 producer lanes.

---
 rtl/mm_pkg.sv | 20 ++
 rtl/mm_d_writeback_arb_rr_arbiter.sv | 32 +++
 rtl/mm_d_writeback_arb.sv | 126 ++++++++++++
 tb/tb_mm_d_writeback_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared defaults, FSM state type and helpers for the matrix-multiply D-result datapath.
package mm_pkg;

    localparam int D_W_DEF          = 32;
    localparam int N1_DEF           = 4;
    localparam int MATRIXSIZE_W_DEF = 16;
    localparam int CNT_W_DEF        = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a lane index; a single lane still needs one bit to be addressable.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_d_writeback_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
    import mm_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = lane_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_d_writeback_arb.sv
// Shares one D-memory write port among N1 producer lanes; each lane fills its own
// address region {lane, cnt} and done pulses once every lane has delivered its words.
module mm_d_writeback_arb
    import mm_pkg::*;
#(
    parameter int D_W          = D_W_DEF,
    parameter int N1           = N1_DEF,
    parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MATRIXSIZE_W-1:0]     M1xM3dN1,
    input  logic [N1-1:0]               in_valid,
    input  logic [N1*D_W-1:0]           in_data,
    output logic [N1-1:0]               in_ready,
    output logic                        wr_en,
    output logic [$clog2(N1)+CNT_W-1:0] wr_addr,
    output logic [D_W-1:0]              wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err
);

    localparam int          ADDR_W = $clog2(N1) + CNT_W;
    localparam int          IW     = lane_w(N1);
    localparam int          SZ_W   = CNT_W + 1;
    localparam logic [31:0] LIMIT  = 32'(1) << CNT_W;

    state_t            state;
    logic [SZ_W-1:0]   size_q;
    logic [CNT_W-1:0]  cnt [N1];
    logic [N1-1:0]     lane_done;
    logic [N1-1:0]     lane_done_nxt;
    logic [N1-1:0]     eligible;
    logic [N1-1:0]     gnt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt_idx;
    logic [D_W-1:0]    lane_data [N1];
    logic [CNT_W-1:0]  cnt_sel;
    logic [31:0]       size_req;
    logic [SZ_W-1:0]   size_clip;
    logic              xfer;
    logic              sel_last;

    always_comb begin
        for (int i = 0; i < N1; i++) begin
            lane_data[i] = in_data[i*D_W +: D_W];
        end
    end

    assign eligible = (state == RUN) ? (in_valid & ~lane_done) : '0;

    rr_arbiter #(.N(N1), .IW(IW)) u_rr_arbiter (
        .req     (eligible),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_ready = gnt;
    assign xfer     = |gnt;

    // A lane finishes on the transfer that brings its word count up to the latched size.
    assign cnt_sel       = cnt[gnt_idx];
    assign sel_last      = (SZ_W'(cnt_sel) + SZ_W'(1)) == size_q;
    assign lane_done_nxt = lane_done | (gnt & {N1{sel_last}});

    assign size_req  = 32'(M1xM3dN1);
    assign size_clip = SZ_W'((size_req > LIMIT) ? LIMIT : size_req);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= '0;
            lane_done <= '0;
            ptr       <= '0;
            cfg_err   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < N1; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                wr_addr      <= ADDR_W'({gnt_idx, cnt_sel});
                wr_data      <= lane_data[gnt_idx];
                cnt[gnt_idx] <= sel_last ? cnt_sel : cnt_sel + CNT_W'(1);
                lane_done    <= lane_done_nxt;
                ptr          <= (int'(gnt_idx) == N1 - 1) ? '0 : gnt_idx + IW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        size_q    <= size_clip;
                        cfg_err   <= (size_req > LIMIT);
                        lane_done <= '0;
                        for (int i = 0; i < N1; i++) begin
                            cnt[i] <= '0;
                        end
                        state <= (size_clip == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (&lane_done_nxt) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_d_writeback_arb.sv
// Self-checking bench for mm_d_writeback_arb: directed table, corner sequences and a
// randomized run, all compared every cycle against a word-count reference model.
module tb_mm_d_writeback_arb;

    localparam int N1    = 4;
    localparam int D_W   = 32;
    localparam int MW    = 16;
    localparam int CNT_W = 10;
    localparam int AW    = 2 + CNT_W;
    localparam int LIM   = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [MW-1:0]     M1xM3dN1;
    logic [N1-1:0]     in_valid;
    logic [N1*D_W-1:0] in_data;
    logic [N1-1:0]     in_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [D_W-1:0]    wr_data;
    logic              busy;
    logic              done;
    logic              cfg_err;

    always #5 clk = ~clk;

    mm_d_writeback_arb #(.D_W(D_W), .N1(N1), .MATRIXSIZE_W(MW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .M1xM3dN1 (M1xM3dN1),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle / 1 draining / 2 finishing, plus words written per lane.
    int             m_mode = 0;
    int             m_size = 0;
    int             m_ptr  = 0;
    int             m_wcnt [N1];
    bit             m_wr_en = 0;
    bit             m_cfg   = 0;
    int             m_addr  = 0;
    logic [D_W-1:0] m_data  = '0;
    bit             m_live  = 0;

    int wr_seen   = 0;
    int done_seen = 0;
    bit done_with_wr = 0;

    typedef struct {
        bit          s;
        int          sz;
        logic [3:0]  v;
        logic [3:0]  rdy;
        bit          we;
        bit          bsy;
        bit          dn;
    } vec_t;

    vec_t tbl [10];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit s, input int sz, input logic [N1-1:0] v);
        int             g;
        int             lane;
        bit             all_done;
        logic [N1-1:0]  exp_rdy;
        @(negedge clk);
        rst      = r;
        start    = s;
        M1xM3dN1 = MW'(sz);
        in_valid = v;
        for (int i = 0; i < N1; i++) in_data[i*D_W +: D_W] = $urandom;
        #1;
        g = -1;
        if (m_mode == 1) begin
            for (int k = 0; k < N1; k++) begin
                lane = (m_ptr + k) % N1;
                if (g < 0 && v[lane] && m_wcnt[lane] < m_size) g = lane;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (m_live) begin
            check_output("in_ready", 64'(in_ready), 64'(exp_rdy));
            check_output("wr_en",    64'(wr_en),    64'(m_wr_en));
            check_output("wr_addr",  64'(wr_addr),  64'(m_addr));
            check_output("wr_data",  64'(wr_data),  64'(m_data));
            check_output("busy",     64'(busy),     64'(m_mode != 0));
            check_output("done",     64'(done),     64'(m_mode == 2));
            check_output("cfg_err",  64'(cfg_err),  64'(m_cfg));
        end
        if (wr_en === 1'b1) wr_seen++;
        if (done === 1'b1) begin
            done_seen++;
            done_with_wr = (wr_en === 1'b1);
        end
        if (r) begin
            m_mode = 0; m_size = 0; m_ptr = 0; m_wr_en = 0; m_cfg = 0;
            m_addr = 0; m_data = '0; m_live = 1;
            for (int i = 0; i < N1; i++) m_wcnt[i] = 0;
        end else begin
            if (g >= 0) begin
                m_wr_en = 1;
                m_addr  = g * LIM + m_wcnt[g];
                m_data  = in_data[g*D_W +: D_W];
                m_wcnt[g]++;
                m_ptr   = (g + 1) % N1;
            end else begin
                m_wr_en = 0;
            end
            case (m_mode)
                0: if (s) begin
                    m_size = (sz > LIM) ? LIM : sz;
                    m_cfg  = (sz > LIM);
                    for (int i = 0; i < N1; i++) m_wcnt[i] = 0;
                    m_mode = (m_size == 0) ? 2 : 1;
                end
                1: begin
                    all_done = 1;
                    for (int i = 0; i < N1; i++) if (m_wcnt[i] != m_size) all_done = 0;
                    if (all_done) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic do_reset();
        apply_stimulus(1, 0, 0, '0);
        apply_stimulus(1, 0, 0, '0);
    endtask

    task automatic run_drain(input int sz, input logic [N1-1:0] v, input int budget);
        int cyc;
        cyc = 0;
        apply_stimulus(0, 1, sz, v);
        while (m_mode != 0 && cyc < budget) begin
            apply_stimulus(0, 0, 0, v);
            cyc++;
        end
        if (m_mode != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain_budget: still busy after %0d cycles, required idle", cyc);
        end
    endtask

    initial begin
        int regrants;
        int cyc;
        bit r;
        bit s;
        int sz;

        rst = 1'b1; start = 1'b0; M1xM3dN1 = '0; in_valid = '0; in_data = '0;

        // s, size, valid -> expected in_ready, wr_en, busy, done (sampled before that edge)
        tbl[0] = '{1, 0, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[1] = '{0, 0, 4'b1111, 4'b0000, 0, 1, 1};
        tbl[2] = '{0, 0, 4'b1111, 4'b0000, 0, 0, 0};
        tbl[3] = '{1, 1, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[4] = '{0, 0, 4'b1111, 4'b0001, 0, 1, 0};
        tbl[5] = '{0, 0, 4'b1111, 4'b0010, 1, 1, 0};
        tbl[6] = '{0, 0, 4'b0100, 4'b0100, 1, 1, 0};
        tbl[7] = '{0, 0, 4'b1000, 4'b1000, 1, 1, 0};
        tbl[8] = '{0, 0, 4'b1111, 4'b0000, 1, 1, 1};
        tbl[9] = '{0, 0, 4'b1111, 4'b0000, 0, 0, 0};

        do_reset();
        check_output("reset_wr_addr", 64'(wr_addr), 64'(0));
        check_output("reset_busy",    64'(busy),    64'(0));

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, tbl[i].s, tbl[i].sz, tbl[i].v);
            check_output($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            check_output($sformatf("tbl%0d_wr_en", i), 64'(wr_en),    64'(tbl[i].we));
            check_output($sformatf("tbl%0d_busy", i),  64'(busy),     64'(tbl[i].bsy));
            check_output($sformatf("tbl%0d_done", i),  64'(done),     64'(tbl[i].dn));
        end

        // All four lanes streaming, three words each.
        do_reset();
        wr_seen = 0; done_seen = 0; done_with_wr = 0;
        run_drain(3, 4'b1111, 60);
        check_output("t1_writes",       64'(wr_seen),      64'(12));
        check_output("t1_done_pulses",  64'(done_seen),    64'(1));
        check_output("t1_done_with_wr", 64'(done_with_wr), 64'(1));

        // Only lane 2 supplies data; the drain must wait on the others.
        do_reset();
        wr_seen = 0;
        apply_stimulus(0, 1, 5, 4'b0100);
        repeat (8) apply_stimulus(0, 0, 0, 4'b0100);
        check_output("t2_writes",    64'(wr_seen), 64'(5));
        check_output("t2_last_addr", 64'(wr_addr), 64'(12'h804));
        check_output("t2_busy_hold", 64'(busy),    64'(1));
        cyc = 0;
        while (m_mode != 0 && cyc < 60) begin
            apply_stimulus(0, 0, 0, 4'b1111);
            cyc++;
        end
        check_output("t2_writes_total", 64'(wr_seen), 64'(20));

        // Lane 1 finishes early and keeps valid high; it must be skipped from then on.
        do_reset();
        apply_stimulus(0, 1, 2, 4'b0010);
        repeat (3) apply_stimulus(0, 0, 0, 4'b0010);
        regrants = 0;
        cyc = 0;
        while (m_mode != 0 && cyc < 60) begin
            apply_stimulus(0, 0, 0, 4'b1111);
            if (in_ready[1] === 1'b1) regrants++;
            cyc++;
        end
        check_output("t3_lane1_regrant", 64'(regrants), 64'(0));

        // Empty drain, then an oversize request clipped to the full lane region.
        wr_seen = 0; done_seen = 0;
        run_drain(0, 4'b1111, 10);
        check_output("t4_zero_writes", 64'(wr_seen),   64'(0));
        check_output("t4_zero_done",   64'(done_seen), 64'(1));
        wr_seen = 0;
        run_drain(2000, 4'b1111, 5000);
        check_output("t4_big_writes",  64'(wr_seen), 64'(4096));
        check_output("t4_cfg_err",     64'(cfg_err), 64'(1));

        // Reset in the middle of a drain, then a fresh drain restarting at cnt 0.
        wr_seen = 0;
        apply_stimulus(0, 1, 10, 4'b1111);
        cyc = 0;
        while (wr_seen < 5 && cyc < 20) begin
            apply_stimulus(0, 0, 0, 4'b1111);
            cyc++;
        end
        apply_stimulus(1, 0, 0, 4'b1111);
        apply_stimulus(0, 0, 0, 4'b1111);
        check_output("t5_wr_en_after_rst", 64'(wr_en), 64'(0));
        check_output("t5_busy_after_rst",  64'(busy),  64'(0));
        wr_seen = 0;
        run_drain(2, 4'b1111, 40);
        check_output("t5_restart_writes", 64'(wr_seen), 64'(8));

        // A second start during RUN must not change the drain length.
        wr_seen = 0;
        apply_stimulus(0, 1, 4, 4'b1111);
        repeat (3) apply_stimulus(0, 0, 0, 4'b1111);
        apply_stimulus(0, 1, 1, 4'b1111);
        cyc = 0;
        while (m_mode != 0 && cyc < 60) begin
            apply_stimulus(0, 0, 0, 4'b1111);
            cyc++;
        end
        check_output("t6_writes", 64'(wr_seen), 64'(16));

        // Randomized drains with sporadic valid, stray starts and rare resets.
        for (int d = 0; d < 40; d++) begin
            sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 7));
            apply_stimulus(0, 1, sz, N1'($urandom));
            cyc = 0;
            while (m_mode != 0 && cyc < 500) begin
                r = ($urandom_range(0, 299) == 0);
                s = ($urandom_range(0, 9) == 0);
                apply_stimulus(r, s, int'($urandom_range(0, 20)), N1'($urandom));
                cyc++;
            end
            if (m_mode != 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL rand_budget: drain %0d still busy, required idle", d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
